// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit holding the HI/LO registers.
// One shift-add or restoring-divide step per cycle; signs are applied in a final FIX cycle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic               is_signed;
    logic [WIDTH:0]     rem_sh, diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    assign is_signed = ~op[0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        // Divide step: bring in the next dividend bit from the top of mag_a.
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], mag_a_q[WIDTH-1]};
        diff     = rem_sh - {1'b0, mag_b_q};
        prod     = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quo      = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem      = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        case (state_q)
            IDLE: begin
                if (mthi_we) hi_d = wd;
                if (mtlo_we) lo_d = wd;
                if (start) begin
                    state_d  = CALC;
                    op_d     = op;
                    sign_a_d = is_signed & src_a[WIDTH-1];
                    sign_b_d = is_signed & src_b[WIDTH-1];
                    mag_a_d  = (is_signed & src_a[WIDTH-1]) ? -src_a : src_a;
                    mag_b_d  = (is_signed & src_b[WIDTH-1]) ? -src_b : src_b;
                    acc_d    = '0;
                    cnt_d    = 6'd32;
                    busy_d   = 1'b1;
                end
            end
            CALC: begin
                cnt_d = cnt_q - 6'd1;
                if (!op_q[1]) begin
                    acc_d   = {acc_q[2*WIDTH-2:0], 1'b0}
                              + (mag_b_q[WIDTH-1] ? {{WIDTH{1'b0}}, mag_a_q} : '0);
                    mag_b_d = {mag_b_q[WIDTH-2:0], 1'b0};
                end else begin
                    mag_a_d = {mag_a_q[WIDTH-2:0], 1'b0};
                    if (!diff[WIDTH])
                        acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == 6'd1) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (!op_q[1]) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else begin
                    // Zero divisor leaves the dividend in the remainder; force LO to all ones.
                    hi_d = rem;
                    lo_d = (mag_b_q == '0) ? '1 : quo;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected HI/LO, a monitor pops on done.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0, src_b = '0, wd = '0;
    logic        mthi_we = 1'b0, mtlo_we = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_tot = 0;
    int n_pass = 0;
    logic [63:0] exp_q[$];

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .mthi_we(mthi_we), .mtlo_we(mtlo_we),
        .wd(wd), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (!reset && done) begin
            check("busy_with_done", {31'b0, busy}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("hi", hi, e[63:32]);
                check("lo", lo, e[31:0]);
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input bit inj,
                          input bit same_mt);
        int nb, nd;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        mtlo_we = same_mt; wd = 32'hDEAD_BEEF;
        exp_q.push_back({eh, el});
        nb = 0; nd = 0;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (busy) nb++;
            if (done) nd++;
            if (inj && i == 4) begin
                start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd3;
                mtlo_we = 1'b1; wd = 32'h1234;
            end else begin
                start = 1'b0; mtlo_we = 1'b0;
            end
            @(negedge clk);
        end
        check("busy_cycles", nb, 32'd33);
        check("done_pulses", nd, 32'd1);
    endtask

    initial begin
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b0;

        run_op(2'b00, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1,         0, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
        run_op(2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 0, 0);
        run_op(2'b11, 32'd7,         32'd2,        32'd1,         32'd3,         0, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 0, 0);
        run_op(2'b11, 32'd100,       32'd0,        32'h64,        32'hFFFF_FFFF, 0, 0);
        run_op(2'b10, 32'hFFFF_FF9C, 32'd0,        32'hFFFF_FF9C, 32'hFFFF_FFFF, 0, 0);
        run_op(2'b00, 32'd6,         32'd7,        32'd0,         32'd42,        1, 0);

        @(negedge clk);
        mthi_we = 1'b1; wd = 32'hABCD;
        @(negedge clk);
        mthi_we = 1'b0;
        check("mthi_hi", hi, 32'hABCD);
        check("mthi_lo_kept", lo, 32'd42);

        // Abort a divide mid-flight with reset.
        @(negedge clk);
        start = 1'b1; op = 2'b10; src_a = 32'hFFFF_FFF9; src_b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_abort_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 0, 1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
